cpu_bus_sequencer: RTL and testbench

- Sits between the microcoded CPU control FSM and the system memory bus.
- Divides the T-cycle enable into 4-phase M-cycles and produces the `m_cycle` strobe that advances the control FSM.
- Latches the control FSM's memory request at the start of each M-cycle, drives the bus read/write strobes and samples read data.
- Loads the instruction register at M-cycle end.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/cpu_t_counter.sv | 36 +++
 rtl/cpu_bus_sequencer.sv | 130 +++++++++++++
 tb/tb_cpu_bus_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: T-phase encoding, bus address width, NOP opcode.
package cpu_pkg;

  typedef logic [1:0] t_phase_t;

  localparam t_phase_t T_PHASE_0 = 2'd0;
  localparam t_phase_t T_PHASE_1 = 2'd1;
  localparam t_phase_t T_PHASE_2 = 2'd2;
  localparam t_phase_t T_PHASE_3 = 2'd3;

  localparam int BUS_ADDR_W = 16;

  localparam logic [7:0] OPCODE_NOP = 8'h00;

endpackage

// File: rtl/cpu_t_counter.sv
// T-phase counter: divides the T-cycle enable into 4-phase M-cycles and
// produces the combinational m_cycle strobe; a stall freezes the phase.
module cpu_t_counter
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       t_cycle_en,
  input  logic       stall,
  output logic [1:0] t_phase,
  output logic       m_cycle
);

  t_phase_t t_phase_q;
  t_phase_t t_phase_d;

  always_comb begin
    t_phase_d = t_phase_q;
    if (t_cycle_en && !stall) begin
      t_phase_d = t_phase_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_phase_q <= T_PHASE_0;
    end else begin
      t_phase_q <= t_phase_d;
    end
  end

  // Stall only ever occurs at phase 2, so it never needs to gate m_cycle here.
  assign m_cycle = t_cycle_en & (t_phase_q == T_PHASE_3) & ~reset;
  assign t_phase = t_phase_q;

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Bus sequencer between the CPU control FSM and the memory bus.
// Optional wait-state support (bus_ready stalls phase 2) when CPU_BUS_WAIT_EN is defined.
module cpu_bus_sequencer
  import cpu_pkg::*;
#(
  parameter int         ADDR_W   = BUS_ADDR_W,
  parameter logic [7:0] IR_RESET = OPCODE_NOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t_cycle_en,
  input  logic              mem_enable,
  input  logic              mem_write,
  input  logic              inst_load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ready,
  output logic              m_cycle,
  output logic [1:0]        t_phase,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [7:0]        rdata,
  output logic [7:0]        instruction_register
);

  logic              req_en_q, req_en_d;
  logic              req_wr_q, req_wr_d;
  logic              req_ir_q, req_ir_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;
  logic              bus_rd_q, bus_rd_d;
  logic              bus_wr_q, bus_wr_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        ir_q, ir_d;
  logic              stall;
  t_phase_t          phase;

`ifdef CPU_BUS_WAIT_EN
  assign stall = t_cycle_en & (phase == T_PHASE_2) & req_en_q & ~bus_ready;
`else
  logic unused_bus_ready;
  assign unused_bus_ready = bus_ready;
  assign stall = 1'b0;
`endif

  cpu_t_counter u_t_counter (
    .clk        (clk),
    .reset      (reset),
    .t_cycle_en (t_cycle_en),
    .stall      (stall),
    .t_phase    (phase),
    .m_cycle    (m_cycle)
  );

  always_comb begin
    req_en_d    = req_en_q;
    req_wr_d    = req_wr_q;
    req_ir_d    = req_ir_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_rd_d    = bus_rd_q;
    bus_wr_d    = bus_wr_q;
    rdata_d     = rdata_q;
    ir_d        = ir_q;
    if (t_cycle_en && !stall) begin
      case (phase)
        T_PHASE_0: begin
          req_en_d = mem_enable;
          req_wr_d = mem_write;
          req_ir_d = inst_load;
          bus_rd_d = mem_enable & ~mem_write;
          if (mem_enable) begin
            bus_addr_d  = addr;
            bus_wdata_d = wdata;
          end
        end
        // Write strobe spans phase 2 only, leaving one T of setup and hold.
        T_PHASE_1: bus_wr_d = req_en_q & req_wr_q;
        T_PHASE_2: begin
          bus_wr_d = 1'b0;
          if (req_en_q && !req_wr_q) begin
            rdata_d = bus_rdata;
          end
        end
        default: begin
          bus_rd_d = 1'b0;
          if (req_ir_q && req_en_q && !req_wr_q) begin
            ir_d = rdata_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_en_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      req_ir_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      rdata_q     <= '0;
      ir_q        <= IR_RESET;
    end else begin
      req_en_q    <= req_en_d;
      req_wr_q    <= req_wr_d;
      req_ir_q    <= req_ir_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      rdata_q     <= rdata_d;
      ir_q        <= ir_d;
    end
  end

  assign t_phase              = phase;
  assign bus_addr             = bus_addr_q;
  assign bus_wdata            = bus_wdata_q;
  assign bus_rd               = bus_rd_q;
  assign bus_wr               = bus_wr_q;
  assign rdata                = rdata_q;
  assign instruction_register = ir_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Self-checking bench for cpu_bus_sequencer: directed scenarios plus random
// traffic against a transaction-level model of the M-cycle.
module tb_cpu_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        t_cycle_en;
  logic        mem_enable;
  logic        mem_write;
  logic        inst_load;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ready;
  logic        m_cycle;
  logic [1:0]  t_phase;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  rdata;
  logic [7:0]  instruction_register;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: ticks completed in the current M-cycle plus the
  // transaction captured at its start.
  int          m_p;
  logic        m_en, m_wr, m_ir;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata, m_irv;

  cpu_bus_sequencer #(.ADDR_W(16), .IR_RESET(8'h00)) dut (
    .clk                  (clk),
    .reset                (reset),
    .t_cycle_en           (t_cycle_en),
    .mem_enable           (mem_enable),
    .mem_write            (mem_write),
    .inst_load            (inst_load),
    .addr                 (addr),
    .wdata                (wdata),
    .bus_rdata            (bus_rdata),
    .bus_ready            (bus_ready),
    .m_cycle              (m_cycle),
    .t_phase              (t_phase),
    .bus_addr             (bus_addr),
    .bus_wdata            (bus_wdata),
    .bus_rd               (bus_rd),
    .bus_wr               (bus_wr),
    .rdata                (rdata),
    .instruction_register (instruction_register)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_en = 0; m_wr = 0; m_ir = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_irv = 8'h00;
  endtask

  task automatic check_outputs();
    check("t_phase", 32'(t_phase), 32'(m_p));
    check("bus_rd", 32'(bus_rd), 32'(m_en && !m_wr && m_p != 0));
    check("bus_wr", 32'(bus_wr), 32'(m_en && m_wr && m_p == 2));
    check("bus_addr", 32'(bus_addr), 32'(m_addr));
    check("bus_wdata", 32'(bus_wdata), 32'(m_wdata));
    check("rdata", 32'(rdata), 32'(m_rdata));
    check("ir", 32'(instruction_register), 32'(m_irv));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic run_cycle(input logic en, input logic me, input logic mw, input logic il,
                           input logic [15:0] a, input logic [7:0] wd, input logic [7:0] rd,
                           input logic rdy);
    bit stall;
    check_outputs();
    t_cycle_en = en; mem_enable = me; mem_write = mw; inst_load = il;
    addr = a; wdata = wd; bus_rdata = rd; bus_ready = rdy;
    #1;
    check("m_cycle", 32'(m_cycle), 32'(en && m_p == 3));
    if (en) begin
      stall = 0;
`ifdef CPU_BUS_WAIT_EN
      stall = (m_p == 2) && m_en && !rdy;
`endif
      if (!stall) begin
        if (m_p == 0) begin
          m_en = me; m_wr = mw; m_ir = il;
          if (me) begin m_addr = a; m_wdata = wd; end
        end else if (m_p == 2) begin
          if (m_en && !m_wr) m_rdata = rd;
        end else if (m_p == 3) begin
          if (m_ir && m_en && !m_wr) m_irv = m_rdata;
        end
        m_p = (m_p + 1) % 4;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_random(input int n, input int en_mode);
    for (int i = 0; i < n; i++) begin
      logic en;
      if (en_mode == 0) en = ($urandom_range(0, 9) < 7);
      else en = (i % 3 == 0);
      run_cycle(en, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    reset = 1'b1; t_cycle_en = 1'b1; mem_enable = 0; mem_write = 0; inst_load = 0;
    addr = '0; wdata = '0; bus_rdata = '0; bus_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_m_cycle", 32'(m_cycle), 32'd0);
    check_outputs();
    reset = 1'b0;

    // Idle M-cycles: m_cycle on every 4th tick, no strobes.
    for (int i = 0; i < 12; i++) run_cycle(1, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 1);

    // Opcode fetch read and a write with inst_load set.
    for (int i = 0; i < 4; i++) run_cycle(1, 1, 0, 1, 16'hC000, 8'h00, 8'h3E, 1);
    check("fetch_ir", 32'(instruction_register), 32'h3E);
    for (int i = 0; i < 4; i++) run_cycle(1, 1, 1, 1, 16'hFF80, 8'hA5, 8'h77, 1);
    check("write_ir_kept", 32'(instruction_register), 32'h3E);
    check("write_data", 32'(bus_wdata), 32'hA5);

    // Sparse T-cycle enable, then dense random traffic.
    run_random(48, 1);
    run_random(400, 0);

    // Align to phase 0, start a read, reset it at phase 2.
    guard = 0;
    while (m_p != 0 && guard < 40) begin
      run_cycle(1, 0, 0, 0, 16'h0, 8'h0, 8'h0, 1);
      guard++;
    end
    check("align_phase0", 32'(m_p), 32'd0);
    run_cycle(1, 1, 0, 1, 16'h1234, 8'h00, 8'h5A, 1);
    run_cycle(1, 1, 0, 1, 16'h1234, 8'h00, 8'h5A, 1);
    check("pre_reset_rd", 32'(bus_rd), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_bus_rd", 32'(bus_rd), 32'd0);
    check("rst_t_phase", 32'(t_phase), 32'd0);
    check("rst_m_cycle", 32'(m_cycle), 32'd0);
    check("rst_ir", 32'(instruction_register), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) run_cycle(1, 0, 0, 0, 16'h0, 8'h0, 8'h0, 1);

    run_random(300, 0);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
